alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of shift-amount bits taken from src_b.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 src_a  input  WIDTH  operand A.
REQ-008 src_b  input  WIDTH  operand B.
REQ-009 alu_control  input  4  opcode.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 alu_result  output  WIDTH  registered result.
REQ-013 zero  output  1  alu_result == 0; registered alongside the result.
REQ-014 busy  output  1  multi-cycle operation in progress.

Function
REQ-015 A request is accepted on a rising edge where in_valid && in_ready; operands and opcode are captured at that edge.
REQ-016 Opcodes:
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 SLL; 0101 SLT (signed); 0110 XOR; 0111 SRL; 1000 SRA (arithmetic, sign-filling).
- 1001 SLTU; 1010 MUL (low WIDTH bits); 1011 MULHU (high WIDTH bits, unsigned); 1100 DIV; 1101 DIVU; 1110 REM; 1111 REMU.
REQ-017 ADD/SUB wrap modulo 2^WIDTH.
REQ-018 Shifts use only src_b[SHW-1:0].
REQ-019 SLT/SLTU return 1 or 0, zero-extended to WIDTH.
REQ-020 States: IDLE, BUSY, DONE; the state after reset is IDLE.
REQ-021 Opcodes 0000-1001 (single-cycle): IDLE -> DONE with the result registered at the accept edge; out_valid is high in the next cycle (latency 1).
REQ-022 Opcodes 1010-1111 (multi-cycle) go IDLE -> BUSY, then run WIDTH iterations:
- MUL/MULHU: shift-add, 2*WIDTH-bit product.
- DIV/DIVU/REM/REMU: restoring division on magnitudes, then sign correction (quotient sign = sign A xor sign B; remainder sign = sign A).
REQ-023 Multi-cycle latency is exactly WIDTH+1 cycles from the accept edge to out_valid high.
REQ-024 busy is high only in BUSY.
REQ-025 Divide by zero bypasses BUSY and completes with latency 1:
- DIV/DIVU return all-ones.
- REM/REMU return src_a.
REQ-026 Signed overflow (DIV/REM with src_a = 100..0 and src_b = all-ones) completes with latency 1: DIV returns src_a, REM returns 0.
REQ-027 DONE: out_valid is high; alu_result and zero hold stable until a cycle with out_ready high.
REQ-028 in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-029 Simultaneous out_ready and in_valid in DONE retires the old result and accepts the new request on the same edge, giving back-to-back single-cycle ops at one per cycle.
REQ-030 DONE with out_ready high and no new request returns to IDLE; out_valid goes low in the next cycle.
REQ-031 Opcode and operand changes while BUSY or DONE are ignored.

Reset
REQ-032 While rst_n is low:
- state = IDLE; out_valid = 0; alu_result = 0; zero = 0; busy = 0; in_ready = 1.
- Iteration counter and internal accumulators are cleared.
REQ-033 Reset asserted during BUSY or DONE aborts the operation with no output; the first accepted request after release behaves exactly as after power-up.

Verification (WIDTH=32)
REQ-034 ADD 0xFFFFFFFF + 1, out_ready=1 -> next cycle out_valid=1, alu_result=0, zero=1.
REQ-035 SRA 0x80000000 by src_b=0x24 (low 5 bits = 4) -> 0xF8000000; SRL of the same inputs -> 0x08000000.
REQ-036 MUL 0xFFFFFFFF * 0xFFFFFFFF -> out_valid 33 cycles after accept, busy high for 32 cycles, alu_result=1; MULHU of the same inputs -> 0xFFFFFFFE.
REQ-037 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000 / -1 -> 0x80000000 at latency 1.
REQ-038 Result SUB 3-3 held with out_ready=0 for 5 cycles -> alu_result=0, zero=1, out_valid stable and in_ready=0 throughout; raising out_ready together with in_valid (XOR 0xF0^0x0F) -> next result 0xFF on the following cycle.
REQ-039 rst_n pulsed low at cycle 10 of a DIVU -> out_valid never asserts for it; a subsequent ADD 2+3 returns 5 at latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request side and a valid/ready
// result side.
//
// Opcodes 0000-1001 are single-cycle: the result is registered at the accept
// edge. MUL/MULHU use a shift-add multiplier. DIV/DIVU/REM/REMU use a
// restoring divider on operand magnitudes, followed by sign correction. The
// iterative ops run WIDTH iterations. Divide-by-zero and signed overflow
// skip the iterations and complete in one cycle.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      request present
//   in_ready      unit can accept a request this cycle
//   src_a, src_b  operands, captured at accept
//   alu_control   opcode, captured at accept
//   out_valid     registered result available (DONE state)
//   out_ready     consumer takes the result
//   alu_result    registered result
//   zero          alu_result == 0, registered with the result
//   busy          an iterative operation is in progress
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000, OP_SUB  = 4'b0001, OP_AND   = 4'b0010, OP_OR   = 4'b0011,
        OP_SLL   = 4'b0100, OP_SLT  = 4'b0101, OP_XOR   = 4'b0110, OP_SRL  = 4'b0111,
        OP_SRA   = 4'b1000, OP_SLTU = 4'b1001, OP_MUL   = 4'b1010, OP_MULHU = 4'b1011,
        OP_DIV   = 4'b1100, OP_DIVU = 4'b1101, OP_REM   = 4'b1110, OP_REMU = 4'b1111
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    // hi/lo: multiplier = {partial product, multiplier bits};
    //        divider    = {partial remainder, dividend/quotient bits}
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] aux_q, aux_d;  // multiplicand or divisor magnitude
    logic             neg_q, neg_d;  // negate the final quotient/remainder
    logic [CW-1:0]    cnt_q, cnt_d;

    op_e              op_in;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_multi, is_div, is_sdiv, is_rem, is_mul;
    logic             div0, ovf;
    logic [WIDTH-1:0] fast_res;

    assign op_in    = op_e'(alu_control);
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign shamt    = src_b[SHW-1:0];
    assign a_neg    = src_a[WIDTH-1];
    assign b_neg    = src_b[WIDTH-1];
    assign a_mag    = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag    = b_neg ? (~src_b + 1'b1) : src_b;

    assign is_multi = (alu_control >= 4'b1010);
    assign is_mul   = (alu_control[3:1] == 3'b101);
    assign is_div   = (alu_control[3:2] == 2'b11);
    assign is_sdiv  = is_div && !alu_control[0];
    assign is_rem   = is_div && alu_control[1];
    assign div0     = is_div && (src_b == '0);
    assign ovf      = is_sdiv && (src_a == MIN_NEG) && (src_b == '1);

    // Result for everything that completes at the accept edge.
    always_comb begin
        fast_res = '0;
        if (div0) begin
            fast_res = is_rem ? src_a : '1;
        end else if (ovf) begin
            fast_res = is_rem ? '0 : src_a;
        end else begin
            unique case (op_in)
                OP_ADD:  fast_res = src_a + src_b;
                OP_SUB:  fast_res = src_a - src_b;
                OP_AND:  fast_res = src_a & src_b;
                OP_OR:   fast_res = src_a | src_b;
                OP_SLL:  fast_res = src_a << shamt;
                OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                OP_XOR:  fast_res = src_a ^ src_b;
                OP_SRL:  fast_res = src_a >> shamt;
                OP_SRA:  fast_res = $signed(src_a) >>> shamt;
                OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
                default: fast_res = '0;
            endcase
        end
    end

    // One iteration of the shift-add multiplier / restoring divider.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_r2, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo, final_res;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, aux_q} : '0);
        div_r2   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_r2 - {1'b0, aux_q};
        div_ge   = !div_diff[WIDTH];
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_r2[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
        unique case (op_q)
            OP_MUL:          final_res = step_lo;
            OP_MULHU:        final_res = step_hi;
            OP_DIV, OP_DIVU: final_res = neg_q ? (~step_lo + 1'b1) : step_lo;
            OP_REM, OP_REMU: final_res = neg_q ? (~step_hi + 1'b1) : step_hi;
            default:         final_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        aux_d   = aux_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    res_d   = final_res;
                    zero_d  = (final_res == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        // A request in DONE with out_ready retires the old result on the same edge.
        if (accept) begin
            op_d = op_in;
            if (is_multi && !div0 && !ovf) begin
                state_d = S_BUSY;
                cnt_d   = '0;
                hi_d    = '0;
                if (is_mul) begin
                    lo_d  = src_a;
                    aux_d = src_b;
                    neg_d = 1'b0;
                end else begin
                    lo_d  = is_sdiv ? a_mag : src_a;
                    aux_d = is_sdiv ? b_mag : src_b;
                    neg_d = is_sdiv && (is_rem ? a_neg : (a_neg ^ b_neg));
                end
            end else begin
                state_d = S_DONE;
                res_d   = fast_res;
                zero_d  = (fast_res == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            res_q   <= '0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            aux_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            aux_q   <= aux_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q == S_BUSY);
    assign alu_result = res_q;
    assign zero       = zero_q;

endmodule
